tap_controller: RTL
===================

TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have parameter IDCODE_VALUE, default 32'h1234_5001, the 32-bit device ID; bit 0 SHALL be 1.
REQ-002 SHALL have ports, in this order:
- TCK  in  1  the single clock; all state changes on rising edge.
- TRST_N  in  1  reset, synchronous, active-low.
- TMS  in  1  test mode select.
- TDI  in  1  serial data in.
- BSR_TDO  in  1  serial output of the boundary scan register chain.
- TDO  out  1  serial data out.
- TDO_EN  out  1  1 while TDO is valid.
- BSR_TDI  out  1  serial input to the BSR chain; equals TDI.
- CAPTURE, SHIFT, UPDATE  out  1 each  BSR phase strobes.
- ENABLE  out  1  1 when the BSR is the selected data register.
- MODE_TEST_NORMAL  out  1  1 when pins/core are driven from update latches.
- MODE_SHIFT_LOAD  out  1  1 = shift path, 0 = parallel load.
- CAPTURE_MODE_INPUT, UPDATE_MODE_INPUT  out  1 each  input-cell capture/update enables.
- CAPTURE_MODE_OUTPUT, UPDATE_MODE_OUTPUT  out  1 each  output-cell capture/update enables.

Function
REQ-003 SHALL implement the 16-state IEEE 1149.1 TAP FSM (TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR), advancing one transition per TCK on TMS.
REQ-004 Five consecutive TCK with TMS=1 SHALL reach TLR from any state.
REQ-005 IR SHALL be 3 bits: a shift stage and a latched register. Opcodes: 000 EXTEST, 001 SAMPLE_PRELOAD, 010 INTEST, 011 IDCODE, 111 BYPASS. Undefined opcodes (100, 101, 110) SHALL decode as BYPASS.
REQ-006 In CAP_IR the IR shift stage SHALL load 3'b001. In SH_IR it SHALL shift right with TDI entering the MSB. In UPD_IR the latched IR SHALL take the shift stage.
REQ-007 In TLR the latched IR SHALL be IDCODE.
REQ-008 The bypass register SHALL be 1 bit: cleared in CAP_DR, loads TDI in SH_DR.
REQ-009 The ID register SHALL be 32 bits: loads IDCODE_VALUE in CAP_DR, shifts right in SH_DR with TDI entering bit 31.
REQ-010 CAPTURE, SHIFT and UPDATE SHALL be decoded combinationally from the current state: CAPTURE=CAP_DR, SHIFT=SH_DR, UPDATE=UPD_DR.
REQ-011 The BSR therefore acts on the TCK edge that leaves each of those states.
REQ-012 MODE_SHIFT_LOAD SHALL be 1 in SH_DR, else 0.
REQ-013 Mode outputs SHALL be registered and decoded from the latched IR, so they change one TCK after UPD_IR or TLR entry:
- EXTEST: ENABLE=1, TEST_NORMAL=1, CAP_IN=1, UPD_IN=0, CAP_OUT=0, UPD_OUT=1.
- INTEST: ENABLE=1, TEST_NORMAL=1, CAP_IN=0, UPD_IN=1, CAP_OUT=1, UPD_OUT=0.
- SAMPLE_PRELOAD: ENABLE=1, TEST_NORMAL=0, all four capture/update modes = 1.
- IDCODE, BYPASS: ENABLE=0, TEST_NORMAL=0, all modes = 0.
REQ-014 TDO SHALL be combinational and SHALL select, in order:
- In SH_IR: IR shift stage bit 0.
- In SH_DR: BSR_TDO for EXTEST, INTEST or SAMPLE_PRELOAD; ID bit 0 for IDCODE; bypass bit otherwise.
- In all other states: TDO=0.
REQ-015 TDO_EN SHALL be 1 only in SH_IR and SH_DR.
REQ-016 Data registers SHALL hold their value in pause and exit states.
REQ-017 Only UPD_IR SHALL change the latched IR.

Reset
REQ-018 When TRST_N=0 at a TCK edge, the controller SHALL reset: FSM=TLR, latched IR=IDCODE, IR shift stage=001, bypass=0, ID register=IDCODE_VALUE.
REQ-019 Mode outputs SHALL reset to the IDCODE decode (all 0).
REQ-020 Reset output values SHALL be: CAPTURE=SHIFT=UPDATE=0, TDO=0, TDO_EN=0.
REQ-021 Reset SHALL take priority over TMS in any state, including mid-shift.
REQ-022 The BSR strobes SHALL never pulse on the reset cycle.

Structure
REQ-023 A shared package tap_pkg SHALL hold the 4-bit state enumeration, the IR width constant and the opcode constants.
REQ-024 The FSM SHALL be a sub-module tap_fsm, with inputs TCK, TRST_N and TMS, and a state output.
REQ-025 IR, DR registers, mode decode and TDO mux SHALL live in tap_controller.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then TMS sequence 0,1,0,0 -> state SH_DR, TDO_EN=1. Shift 32 TCK with TDI=0 -> TDO emits 32'h1234_5001 LSB first.
- Load IR=111 (TMS 0,1,1,0,0 then shift 1,1,1 with TMS=1 on the last bit, then 1,0) -> all mode outputs 0. A DR scan then gives TDI delayed by exactly 1 TCK on TDO, with the first bit 0.
- Load IR=000 -> next TCK after UPD_IR: ENABLE=1, TEST_NORMAL=1, UPD_OUT=1, CAP_IN=1. A DR scan gives CAPTURE high for 1 TCK, SHIFT high for N TCK, UPDATE high for 1 TCK, and TDO=BSR_TDO.
- Any state, TMS=1 for 5 TCK -> TLR, mode outputs return to 0 one TCK later.
- A CAP_IR/SH_IR scan with TDI=0 -> TDO emits 1,0,0.
- Load IR=101 -> decodes as BYPASS.
- TRST_N=0 during SH_DR -> next cycle TLR, SHIFT=0, TDO_EN=0.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, IR width, opcodes and mode decode.
// Pure types and constants. No clocking and no backpressure.
package tap_pkg;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_t;

    localparam int IR_W = 3;

    localparam logic [IR_W-1:0] OP_EXTEST         = 3'b000;
    localparam logic [IR_W-1:0] OP_SAMPLE_PRELOAD = 3'b001;
    localparam logic [IR_W-1:0] OP_INTEST         = 3'b010;
    localparam logic [IR_W-1:0] OP_IDCODE         = 3'b011;
    localparam logic [IR_W-1:0] OP_BYPASS         = 3'b111;

    localparam logic [IR_W-1:0] IR_CAPTURE_VAL = 3'b001;

    typedef struct packed {
        logic enable;
        logic test_normal;
        logic cap_in;
        logic upd_in;
        logic cap_out;
        logic upd_out;
    } mode_t;

    // Undefined opcodes fall through to the all-zero BYPASS decode.
    function automatic mode_t decode_mode(input logic [IR_W-1:0] op);
        mode_t m;
        m = '0;
        case (op)
            OP_EXTEST:         m = '{enable: 1'b1, test_normal: 1'b1, cap_in: 1'b1,
                                     upd_in: 1'b0, cap_out: 1'b0, upd_out: 1'b1};
            OP_INTEST:         m = '{enable: 1'b1, test_normal: 1'b1, cap_in: 1'b0,
                                     upd_in: 1'b1, cap_out: 1'b1, upd_out: 1'b0};
            OP_SAMPLE_PRELOAD: m = '{enable: 1'b1, test_normal: 1'b0, cap_in: 1'b1,
                                     upd_in: 1'b1, cap_out: 1'b1, upd_out: 1'b1};
            default:           m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine stepped by TMS on every rising TCK.
// State is registered, one transition per TCK. No backpressure.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output tap_state_t state
);

    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:    state <= TMS ? TLR    : RTI;
                RTI:    state <= TMS ? SEL_DR : RTI;
                SEL_DR: state <= TMS ? SEL_IR : CAP_DR;
                CAP_DR: state <= TMS ? EX1_DR : SH_DR;
                SH_DR:  state <= TMS ? EX1_DR : SH_DR;
                EX1_DR: state <= TMS ? UPD_DR : PA_DR;
                PA_DR:  state <= TMS ? EX2_DR : PA_DR;
                EX2_DR: state <= TMS ? UPD_DR : SH_DR;
                UPD_DR: state <= TMS ? SEL_DR : RTI;
                SEL_IR: state <= TMS ? TLR    : CAP_IR;
                CAP_IR: state <= TMS ? EX1_IR : SH_IR;
                SH_IR:  state <= TMS ? EX1_IR : SH_IR;
                EX1_IR: state <= TMS ? UPD_IR : PA_IR;
                PA_IR:  state <= TMS ? EX2_IR : PA_IR;
                EX2_IR: state <= TMS ? UPD_IR : SH_IR;
                UPD_IR: state <= TMS ? SEL_DR : RTI;
                default: state <= TLR;
            endcase
        end
    end

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: IR, bypass and ID registers, BSR strobes, TDO mux.
// Strobes and TDO are combinational from state; mode outputs lag the IR by one TCK. No backpressure.
module tap_controller
    import tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
)(
    input  logic TCK,
    input  logic TRST_N,
    input  logic TMS,
    input  logic TDI,
    input  logic BSR_TDO,
    output logic TDO,
    output logic TDO_EN,
    output logic BSR_TDI,
    output logic CAPTURE,
    output logic SHIFT,
    output logic UPDATE,
    output logic ENABLE,
    output logic MODE_TEST_NORMAL,
    output logic MODE_SHIFT_LOAD,
    output logic CAPTURE_MODE_INPUT,
    output logic UPDATE_MODE_INPUT,
    output logic CAPTURE_MODE_OUTPUT,
    output logic UPDATE_MODE_OUTPUT
);

    tap_state_t      state;
    logic [IR_W-1:0] ir_shift;
    logic [IR_W-1:0] ir_latch;
    logic [IR_W-1:0] ir_eff;
    logic            bypass_q;
    logic [31:0]     id_q;
    mode_t           mode_q;

    tap_fsm u_fsm (
        .TCK    (TCK),
        .TRST_N (TRST_N),
        .TMS    (TMS),
        .state  (state)
    );

    // TLR forces IDCODE immediately, before the latch itself is rewritten.
    assign ir_eff = (state == TLR) ? OP_IDCODE : ir_latch;

    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            ir_shift <= IR_CAPTURE_VAL;
            ir_latch <= OP_IDCODE;
            bypass_q <= 1'b0;
            id_q     <= IDCODE_VALUE;
            mode_q   <= '0;
        end else begin
            mode_q <= decode_mode(ir_eff);
            case (state)
                TLR:    ir_latch <= OP_IDCODE;
                CAP_IR: ir_shift <= IR_CAPTURE_VAL;
                SH_IR:  ir_shift <= {TDI, ir_shift[IR_W-1:1]};
                UPD_IR: ir_latch <= ir_shift;
                CAP_DR: begin
                    bypass_q <= 1'b0;
                    id_q     <= IDCODE_VALUE;
                end
                SH_DR: begin
                    bypass_q <= TDI;
                    id_q     <= {TDI, id_q[31:1]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state == SH_IR) begin
            TDO = ir_shift[0];
        end else if (state == SH_DR) begin
            case (ir_latch)
                OP_EXTEST, OP_INTEST, OP_SAMPLE_PRELOAD: TDO = BSR_TDO;
                OP_IDCODE:                               TDO = id_q[0];
                default:                                 TDO = bypass_q;
            endcase
        end
    end

    assign TDO_EN  = (state == SH_IR) || (state == SH_DR);
    assign BSR_TDI = TDI;

    // Gated with TRST_N so the BSR never sees a strobe on a reset edge.
    assign CAPTURE = TRST_N && (state == CAP_DR);
    assign SHIFT   = TRST_N && (state == SH_DR);
    assign UPDATE  = TRST_N && (state == UPD_DR);

    assign MODE_SHIFT_LOAD     = (state == SH_DR);
    assign ENABLE              = mode_q.enable;
    assign MODE_TEST_NORMAL    = mode_q.test_normal;
    assign CAPTURE_MODE_INPUT  = mode_q.cap_in;
    assign UPDATE_MODE_INPUT   = mode_q.upd_in;
    assign CAPTURE_MODE_OUTPUT = mode_q.cap_out;
    assign UPDATE_MODE_OUTPUT  = mode_q.upd_out;

endmodule
